// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps fetch/decode/execute (T0..T5) for
// register-register ALU ops, NOP and HALT, and emits the datapath strobes.
module control_sequencer #(
  parameter int REG_COUNT = 16,
  parameter int ICOUNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic [31:0]          ir,
  output logic                 pc_out,
  output logic                 inc_pc,
  output logic                 mar_in,
  output logic                 z_in,
  output logic                 zlow_out,
  output logic                 pc_in,
  output logic                 read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic                 y_in,
  output logic [REG_COUNT-1:0] r_out,
  output logic [REG_COUNT-1:0] r_in,
  output logic [3:0]           alu_op,
  output logic                 instr_done,
  output logic                 halted,
  output logic                 illegal,
  output logic [2:0]           t_state,
  output logic [ICOUNT_W-1:0]  icount
);

  // state  | meaning
  // S_IDLE | waiting for run before fetching
  // S_T0   | PC -> MAR, Z <= PC+1
  // S_T1   | Z -> PC, memory read into MDR
  // S_T2   | MDR -> IR
  // S_T3   | decode; binary ops load Y, NOP/HALT/illegal retire here
  // S_T4   | ALU operation into Z
  // S_T5   | Z -> destination register, retire
  // S_HALT | sticky halt until clear
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_HALT = 3'd6,
    S_IDLE = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ICOUNT_W-1:0]  r_icount;

  logic [4:0]           w_opcode;
  logic [3:0]           w_ra, w_rb, w_rc;
  logic                 w_binary, w_unary, w_halt, w_nop;
  logic [3:0]           w_alu_code;
  logic                 w_unused;

  assign w_opcode = ir[31:27];
  assign w_ra     = ir[26:23];
  assign w_rb     = ir[22:19];
  assign w_rc     = ir[18:15];
  assign w_unused = ^ir[14:0];

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (int'(idx) == i) v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    w_binary   = 1'b0;
    w_unary    = 1'b0;
    w_halt     = 1'b0;
    w_nop      = 1'b0;
    w_alu_code = 4'd0;
    case (w_opcode)
      5'b00011: begin w_binary = 1'b1; w_alu_code = 4'd1; end
      5'b00100: begin w_binary = 1'b1; w_alu_code = 4'd2; end
      5'b00101: begin w_binary = 1'b1; w_alu_code = 4'd3; end
      5'b00110: begin w_binary = 1'b1; w_alu_code = 4'd4; end
      5'b00111: begin w_unary  = 1'b1; w_alu_code = 4'd5; end
      5'b01000: begin w_unary  = 1'b1; w_alu_code = 4'd6; end
      5'b11010: w_nop  = 1'b1;
      5'b11011: w_halt = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    pc_out      = 1'b0;
    inc_pc      = 1'b0;
    mar_in      = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    pc_in       = 1'b0;
    read        = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    r_out       = '0;
    r_in        = '0;
    alu_op      = 4'd0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_state_nxt = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        w_state_nxt = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
        w_state_nxt = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        w_state_nxt = S_T3;
      end
      S_T3: begin
        if (w_binary) begin
          r_out = onehot(w_rb); y_in = 1'b1;
          w_state_nxt = S_T4;
        end else if (w_unary) begin
          w_state_nxt = S_T4;
        end else if (w_halt) begin
          instr_done  = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          // undefined opcodes retire like NOP, flagged by illegal
          instr_done  = 1'b1;
          illegal     = ~w_nop;
          w_state_nxt = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        r_out  = w_unary ? onehot(w_rb) : onehot(w_rc);
        alu_op = w_alu_code;
        z_in   = 1'b1;
        w_state_nxt = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1; r_in = onehot(w_ra); instr_done = 1'b1;
        w_state_nxt = run ? S_T0 : S_IDLE;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_icount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      if (instr_done) r_icount <= r_icount + 1'b1;
    end
  end

  assign halted  = (r_state == S_HALT);
  assign t_state = (r_state == S_HALT) ? 3'd7 : r_state;
  assign icount  = r_icount;

endmodule
